// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
//   state_t : responder FSM states (IDLE, BUSY, RESP)
//   op_t    : latched access type (OP_RD, OP_WR)
//   WORD_W  : data word width in bits
package mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // A word access is misaligned when either byte-offset bit is set.
  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage data-memory bus between the pipeline (master) and the responder (slave).
//   MemRead/MemWrite/addr/wd : request from the pipeline
//   rd/ready/err             : registered completion from the responder
//   stall                    : combinational hold request back to the pipeline
interface dmem_responder_if;

  logic                       MemRead;
  logic                       MemWrite;
  logic [mem_pkg::WORD_W-1:0] addr;
  logic [mem_pkg::WORD_W-1:0] wd;
  logic [mem_pkg::WORD_W-1:0] rd;
  logic                       ready;
  logic                       stall;
  logic                       err;

  modport master (
    output MemRead, MemWrite, addr, wd,
    input  rd, ready, stall, err
  );

  modport slave (
    input  MemRead, MemWrite, addr, wd,
    output rd, ready, stall, err
  );

endinterface

// File: rtl/dmem_array.sv
// Word-addressed data RAM: synchronous write, combinational read, and an
// asynchronous clear of every word on reset.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, clears all words
//   we    : write enable for this edge
//   idx   : word index used for both read and write
//   wdata : write data
//   rdata : contents of word idx (combinational)
module dmem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata
);

  logic [WORD_W-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (we) begin
      mem_reg[idx] <= wdata;
    end
  end

  assign rdata = mem_reg[idx];

endmodule

// File: rtl/dmem_responder.sv
// Target side of the MEM-stage data-memory interface. Accepts one read or
// write at a time, holds the pipeline with stall for WAIT_CYCLES+1 cycles,
// then pulses ready for one cycle with the read data and misalignment flag.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   bus    : slave side of dmem_responder_if (request in, rd/ready/err/stall out)
//   rd_cnt : completed reads, saturating
//   wr_cnt : completed writes (including simultaneous read+write), saturating
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t              state_reg, state_next;
  logic [3:0]          count_reg, count_next;
  op_t                 op_reg;
  logic [IDX_W+1:0]    addr_reg;
  logic [WORD_W-1:0]   wd_reg;
  logic                latch_en;
  logic                stall_c;

  logic [WORD_W-1:0]   rd_reg;
  logic                ready_reg;
  logic                err_reg;
  logic [CNT_W-1:0]    rd_cnt_reg;
  logic [CNT_W-1:0]    wr_cnt_reg;

  logic                req;
  op_t                 req_op;
  op_t                 acc_op;
  logic [IDX_W+1:0]    acc_addr;
  logic [WORD_W-1:0]   acc_wd;
  logic                acc_ok;
  logic                commit;
  logic                array_we;
  logic [WORD_W-1:0]   array_rdata;
  logic                addr_unused;

  assign req    = bus.MemRead | bus.MemWrite;
  assign req_op = bus.MemWrite ? OP_WR : OP_RD;

  // Address bits above the array index wrap and are deliberately dropped.
  assign addr_unused = ^bus.addr[WORD_W-1:IDX_W+2];

  // With zero wait states the access commits on the same edge that accepts
  // the request, so the live bus values are used while still in IDLE.
  assign acc_op   = (state_reg == IDLE) ? req_op : op_reg;
  assign acc_addr = (state_reg == IDLE) ? bus.addr[IDX_W+1:0] : addr_reg;
  assign acc_wd   = (state_reg == IDLE) ? bus.wd : wd_reg;
  assign acc_ok   = !is_misaligned(acc_addr[1:0]);

  // The array access happens on the edge that enters RESP.
  assign commit   = (state_next == RESP);
  assign array_we = commit && (acc_op == OP_WR) && acc_ok;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (array_we),
    .idx   (acc_addr[IDX_W+1:2]),
    .wdata (acc_wd),
    .rdata (array_rdata)
  );

  // Next-state and stall logic.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    latch_en   = 1'b0;
    stall_c    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          latch_en = 1'b1;
          stall_c  = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_next = BUSY;
            count_next = WAIT_INIT;
          end else begin
            state_next = RESP;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (count_reg == 4'd0) begin
          state_next = RESP;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      RESP: begin
        // Requests seen here are ignored; the pipeline re-presents them in IDLE.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state and latched request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= 4'd0;
      op_reg    <= OP_RD;
      addr_reg  <= '0;
      wd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (latch_en) begin
        op_reg   <= req_op;
        addr_reg <= bus.addr[IDX_W+1:0];
        wd_reg   <= bus.wd;
      end
    end
  end

  // Registered completion outputs and saturating access counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_reg     <= '0;
      ready_reg  <= 1'b0;
      err_reg    <= 1'b0;
      rd_cnt_reg <= '0;
      wr_cnt_reg <= '0;
    end else begin
      ready_reg <= commit;
      err_reg   <= commit && !acc_ok;
      if (commit) begin
        // Writes and misaligned reads return zero.
        rd_reg <= ((acc_op == OP_RD) && acc_ok) ? array_rdata : '0;
        if (acc_op == OP_WR) begin
          if (wr_cnt_reg != {CNT_W{1'b1}}) begin
            wr_cnt_reg <= wr_cnt_reg + CNT_W'(1);
          end
        end else begin
          if (rd_cnt_reg != {CNT_W{1'b1}}) begin
            rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
          end
        end
      end else if (state_reg == RESP) begin
        // Data is only presented during RESP; clear it on the way back to IDLE.
        rd_reg <= '0;
      end
    end
  end

  assign bus.rd    = rd_reg;
  assign bus.ready = ready_reg;
  assign bus.err   = err_reg;
  assign bus.stall = stall_c;
  assign rd_cnt    = rd_cnt_reg;
  assign wr_cnt    = wr_cnt_reg;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Target side of the pipeline's MEM-stage data-memory interface: responds to the MemRead/MemWrite/addr/wd requests the processor issues.
- Models a multi-cycle data RAM with a programmable number of wait states.
- Holds the pipeline via `stall` until each access completes, then returns read data with a one-cycle ready pulse.
- Keeps saturating read/write access counters and flags misaligned accesses.

Parameters:
- DEPTH, 64, number of 32-bit words in the array (power of two, ≥4)
- WAIT_CYCLES, 2, extra busy cycles per access (0..15)
- CNT_W, 16, width of access counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- MemRead  in  1  read request from MEM stage
- MemWrite  in  1  write request from MEM stage
- addr  in  32  byte address
- wd  in  32  write data
- rd  out  32  read data, valid while ready=1
- ready  out  1  one-cycle completion pulse
- stall  out  1  freeze PC/IF_ID/ID_EX/EX_MEM while high
- err  out  1  misaligned access, pulses with ready
- rd_cnt  out  CNT_W  completed reads, saturating
- wr_cnt  out  CNT_W  completed writes, saturating

Behaviour:
- Reset: async, active-high.
  - rd=0, ready=0, stall=0, err=0, rd_cnt=0, wr_cnt=0, state=IDLE, counter=0.
  - All array words cleared to 0.
- States:
  - IDLE: req = MemRead|MemWrite.
    - On req: latch addr, wd and op (op=write if MemWrite, else read).
    - Go to BUSY with count=WAIT_CYCLES-1 if WAIT_CYCLES>0, else go straight to RESP.
  - BUSY: decrement count; at count==0 go to RESP.
  - RESP: return to IDLE unconditionally. Requests present in RESP are not accepted.
- Access commit:
  - The array access occurs on the edge entering RESP, using the latched op/addr/wd.
  - Word index = addr[log2(DEPTH)+1:2]; upper address bits ignored (wrap).
- Outputs in RESP:
  - ready=1; rd = array word for reads, 0 for writes.
  - err=1 if addr[1:0]!=0. A misaligned access performs no write, returns rd=0, and still counts.
- stall (combinational):
  - =1 in IDLE while req=1, and in all BUSY cycles.
  - =0 in RESP and in IDLE without req.
  - The pipeline advances at the end of RESP and MEM_WB captures rd at that edge.
- Latency:
  - Request seen in IDLE at cycle T; RESP at T+WAIT_CYCLES+1.
  - Total stall cycles = WAIT_CYCLES+1 per access.
- Simultaneous MemRead & MemWrite: treated as write. Counts only in wr_cnt.
- Back-to-back: the next request is accepted in the IDLE cycle after RESP. There is no gap beyond that cycle.
- Read-after-write to the same word returns the new data.
- Counters: increment on entry to RESP; hold at all-ones, no wrap.
- ready, err and rd are registered; rd holds its last value except that it returns to 0 in IDLE.
- Reset mid-operation (BUSY): access aborted, no write committed, counters cleared.
- Input changes while BUSY are ignored because the request is latched. The pipeline is required to hold inputs stable while stall=1.

Decomposition:
- Shared package `mem_pkg`:
  - state enum {IDLE, BUSY, RESP}
  - op enum {OP_RD, OP_WR}
  - WORD_W=32
- One natural sub-module, `dmem_array`: synchronous-write word RAM with async clear, write enable and combinational read by index. FSM, counters and handshake stay in the top.

Test Plan:
- WAIT_CYCLES=2: write addr=0x10, wd=0xDEADBEEF; next request read addr=0x10.
  - Expected: stall high 3 cycles per access, ready pulse at T+3, rd=0xDEADBEEF, wr_cnt=1, rd_cnt=1.
- WAIT_CYCLES=0:
  - Expected: stall is 1 cycle, ready at T+1.
  - Back-to-back reads of 0x0 and 0x4 after writes 0x11111111/0x22222222 return those values in order, one idle cycle between ready pulses.
- Misaligned write addr=0x13, wd=0xFFFFFFFF, then read 0x10.
  - Expected: err=1 with ready on the write, word unchanged (reads 0), wr_cnt increments.
- Assert rst during BUSY of a write to 0x20=0xCAFEF00D, then read 0x20.
  - Expected: all outputs 0 immediately, read returns 0, counters 0.
- MemRead=1 and MemWrite=1 with addr=0x8, wd=0x5A5A5A5A.
  - Expected: treated as write; later read 0x8 returns 0x5A5A5A5A, rd_cnt counts only the later read.
- CNT_W=4: 20 reads.
  - Expected: rd_cnt saturates at 15.
  - Address 0x100 with DEPTH=64 wraps to word 0.
